// File: rtl/a2rt_seq.sv
// rtl/a2rt_seq.sv - ASCII render sequencer: pixel/cell counters, bank swap, 1-deep output stage
module a2rt_seq #(
    parameter int SCREEN_WIDTH  = 800,
    parameter int SCREEN_HEIGHT = 600,
    parameter int ASCII_WIDTH   = 8,
    parameter int ASCII_HEIGHT  = 16,
    localparam int XW = $clog2(SCREEN_WIDTH),
    localparam int CW = $clog2(SCREEN_WIDTH / ASCII_WIDTH),
    localparam int LW = $clog2(ASCII_HEIGHT),
    localparam int RW = $clog2((SCREEN_HEIGHT + ASCII_HEIGHT - 1) / ASCII_HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_i,
    input  logic          rts_i,
    input  logic          eow_i,
    output logic          rtr_o,
    input  logic          rtr_i,
    output logic          rts_o,
    output logic          eow_o,
    output logic [XW-1:0] pix_x,
    output logic [CW-1:0] cell_col,
    output logic [LW-1:0] line_in_cell,
    output logic [RW-1:0] cell_row,
    output logic          bank_sel,
    output logic          acc_en,
    output logic          acc_clear,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_long,
    input  logic          err_clr
);
    localparam int YW  = $clog2(SCREEN_HEIGHT);
    localparam int AWL = $clog2(ASCII_WIDTH);
    localparam logic [XW-1:0] X_LAST      = XW'(SCREEN_WIDTH - 1);
    localparam logic [XW-1:0] X_CELL_MASK = XW'(ASCII_WIDTH - 1);
    localparam logic [LW-1:0] LIC_LAST    = LW'(ASCII_HEIGHT - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(SCREEN_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, SWAP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [YW-1:0] line_cnt;
    logic          swap_eof;
    logic          accept;
    logic          x_last;
    logic          line_end;
    logic          band_end;
    logic          frame_end;

    assign rtr_o     = (state == ACTIVE) & (~rts_o | rtr_i);
    assign accept    = rts_i & rtr_o;
    assign x_last    = (pix_x == X_LAST);
    assign line_end  = accept & (eow_i | x_last);
    // Frame end counts real lines, so a partial last band still closes the frame.
    assign frame_end = line_end & (line_cnt == Y_LAST);
    assign band_end  = line_end & ((line_in_cell == LIC_LAST) | (line_cnt == Y_LAST));
    assign acc_en    = accept;
    assign acc_clear = accept & (line_in_cell == '0) & ((pix_x & X_CELL_MASK) == '0);
    assign cell_col  = CW'(pix_x >> AWL);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable_i) state_nxt = ACTIVE;
            ACTIVE:  if (band_end) state_nxt = SWAP;
            SWAP:    state_nxt = (swap_eof && !enable_i) ? IDLE : ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            swap_eof     <= 1'b0;
            pix_x        <= '0;
            line_in_cell <= '0;
            cell_row     <= '0;
            line_cnt     <= '0;
            bank_sel     <= 1'b0;
            rts_o        <= 1'b0;
            eow_o        <= 1'b0;
            frame_done   <= 1'b0;
            err_short    <= 1'b0;
            err_long     <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= frame_end;
            if (band_end) begin
                swap_eof <= frame_end;
                bank_sel <= ~bank_sel;
            end
            if (accept) begin
                rts_o <= 1'b1;
                eow_o <= line_end;
            end else if (rtr_i) begin
                rts_o <= 1'b0;
            end
            if (line_end) begin
                pix_x <= '0;
                if (frame_end) begin
                    line_in_cell <= '0;
                    cell_row     <= '0;
                    line_cnt     <= '0;
                end else begin
                    line_cnt     <= line_cnt + YW'(1);
                    line_in_cell <= line_in_cell + LW'(1);
                    if (line_in_cell == LIC_LAST) cell_row <= cell_row + RW'(1);
                end
            end else if (accept) begin
                pix_x <= pix_x + XW'(1);
            end
            // A new error in the clearing cycle wins over err_clr.
            err_short <= (err_short & ~err_clr) | (accept & eow_i & ~x_last);
            err_long  <= (err_long & ~err_clr) | (accept & x_last & ~eow_i);
        end
    end
endmodule

// File: tb/tb_a2rt_seq.sv
// tb/tb_a2rt_seq.sv - randomized scoreboard bench for a2rt_seq
module tb_a2rt_seq;
    localparam int W  = 24;
    localparam int H  = 20;
    localparam int AW = 8;
    localparam int AH = 8;
    localparam int XW = $clog2(W);
    localparam int CW = $clog2(W / AW);
    localparam int LW = $clog2(AH);
    localparam int RW = $clog2((H + AH - 1) / AH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable_i = 1'b0;
    logic rts_i = 1'b0;
    logic eow_i = 1'b0;
    logic rtr_i = 1'b0;
    logic err_clr = 1'b0;
    logic rtr_o, rts_o, eow_o, bank_sel, acc_en, acc_clear, frame_done, err_short, err_long;
    logic [XW-1:0] pix_x;
    logic [CW-1:0] cell_col;
    logic [LW-1:0] line_in_cell;
    logic [RW-1:0] cell_row;

    a2rt_seq #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .ASCII_WIDTH  (AW),
        .ASCII_HEIGHT (AH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable_i    (enable_i),
        .rts_i       (rts_i),
        .eow_i       (eow_i),
        .rtr_o       (rtr_o),
        .rtr_i       (rtr_i),
        .rts_o       (rts_o),
        .eow_o       (eow_o),
        .pix_x       (pix_x),
        .cell_col    (cell_col),
        .line_in_cell(line_in_cell),
        .cell_row    (cell_row),
        .bank_sel    (bank_sel),
        .acc_en      (acc_en),
        .acc_clear   (acc_clear),
        .frame_done  (frame_done),
        .err_short   (err_short),
        .err_long    (err_long),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ds_mode = 0;
    int fd_seen = 0;
    int fd_exp  = 0;
    bit sb[$];

    // Reference model: position in the frame plus sticky error state.
    int m_x    = 0;
    int m_line = 0;
    bit m_bank = 1'b0;
    bit m_es   = 1'b0;
    bit m_el   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rts_i = 1'b0;
        repeat (n) sync();
    endtask

    initial forever begin
        sync();
        case (ds_mode)
            0:       rtr_i = ($urandom_range(0, 3) != 0);
            1:       rtr_i = 1'b0;
            default: rtr_i = 1'b1;
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rts_o && rtr_i) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_underflow: output beat with no expected entry");
                end else begin
                    chk("eow_o", eow_o, sb.pop_front());
                end
            end
            if (frame_done) fd_seen++;
        end
    end

    task automatic send_beat(input bit eow, input bit clr);
        int n = 0;
        bit le, be, fe;
        rts_i = 1'b1;
        eow_i = eow;
        err_clr = clr;
        @(negedge clk);
        while (!rtr_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rtr_o) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: rtr_o stayed 0 at line %0d x %0d", m_line, m_x);
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
        chk("acc_en", acc_en, 1);
        chk("pix_x", pix_x, m_x);
        chk("cell_col", cell_col, m_x / AW);
        chk("line_in_cell", line_in_cell, m_line % AH);
        chk("cell_row", cell_row, m_line / AH);
        chk("acc_clear", acc_clear, (m_line % AH == 0) && (m_x % AW == 0));
        chk("bank_sel", bank_sel, m_bank);
        if (!clr) begin
            chk("err_short", err_short, m_es);
            chk("err_long", err_long, m_el);
        end
        le = eow || (m_x == W - 1);
        fe = le && (m_line == H - 1);
        be = le && ((m_line % AH == AH - 1) || fe);
        if (clr) begin
            m_es = 1'b0;
            m_el = 1'b0;
        end
        if (eow && m_x < W - 1) m_es = 1'b1;
        if (!eow && m_x == W - 1) m_el = 1'b1;
        sb.push_back(le);
        if (le) begin
            m_x = 0;
            m_line = fe ? 0 : m_line + 1;
        end else begin
            m_x++;
        end
        if (be) m_bank = ~m_bank;
        if (fe) fd_exp++;
        sync();
        rts_i = 1'b0;
        eow_i = 1'b0;
        err_clr = 1'b0;
        if (be) begin
            @(negedge clk);
            chk("swap_rtr_o", rtr_o, 0);
            chk("frame_done", frame_done, fe);
            sync();
        end
    endtask

    // mode 0: eow on last pixel, 1: early eow after len beats, 2: never eow
    task automatic send_line(input int mode, input int len, input bit rnd);
        bit done = 1'b0;
        int i = 0;
        while (!done) begin
            bit e;
            case (mode)
                0:       e = (m_x == W - 1);
                1:       e = (i == len - 1);
                default: e = 1'b0;
            endcase
            done = e || (m_x == W - 1);
            send_beat(e, 1'b0);
            i++;
            if (rnd && $urandom_range(0, 7) == 0) idle($urandom_range(1, 2));
        end
    endtask

    task automatic rand_line(input bit rnd);
        int r = rnd ? $urandom_range(0, 9) : 0;
        if (r < 7)      send_line(0, 0, rnd);
        else if (r < 8) send_line(1, $urandom_range(1, W - 1), rnd);
        else            send_line(2, 0, rnd);
    endtask

    task automatic finish_frame(input bit rnd);
        do rand_line(rnd); while (m_line != 0);
    endtask

    task automatic drain();
        int n = 0;
        ds_mode = 2;
        rts_i = 1'b0;
        while ((sb.size() != 0 || rts_o) && n < 50) begin
            sync();
            n++;
        end
        chk("drain_done", (sb.size() == 0) && !rts_o, 1);
    endtask

    task automatic clear_errs();
        rts_i = 1'b0;
        err_clr = 1'b1;
        sync();
        err_clr = 1'b0;
        m_es = 1'b0;
        m_el = 1'b0;
        @(negedge clk);
        chk("clr_err_short", err_short, 0);
        chk("clr_err_long", err_long, 0);
        sync();
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_pix_x"}, pix_x, 0);
        chk({tag, "_cell_col"}, cell_col, 0);
        chk({tag, "_line_in_cell"}, line_in_cell, 0);
        chk({tag, "_cell_row"}, cell_row, 0);
        chk({tag, "_bank_sel"}, bank_sel, 0);
        chk({tag, "_rts_o"}, rts_o, 0);
        chk({tag, "_eow_o"}, eow_o, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_err_short"}, err_short, 0);
        chk({tag, "_err_long"}, err_long, 0);
        chk({tag, "_rtr_o"}, rtr_o, 0);
        chk({tag, "_acc_en"}, acc_en, 0);
        sync();
    endtask

    initial begin
        #500000;
        n_tests++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        bit exp_eow;
        int bp_x;
        rst = 1'b1;
        repeat (3) sync();
        check_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_enable_rtr_o", rtr_o, 0);
            sync();
        end

        // Continuous streaming with full lines, then randomized traffic.
        enable_i = 1'b1;
        ds_mode = 2;
        finish_frame(1'b0);
        @(negedge clk);
        chk("f1_pix_x", pix_x, 0);
        chk("f1_line_in_cell", line_in_cell, 0);
        chk("f1_cell_row", cell_row, 0);
        chk("f1_bank_sel", bank_sel, m_bank);
        sync();
        ds_mode = 0;
        finish_frame(1'b1);

        // Short line, long line, clear, and set-beats-clear.
        clear_errs();
        send_line(1, 13, 1'b0);
        @(negedge clk);
        chk("short_err_short", err_short, 1);
        chk("short_pix_x", pix_x, 0);
        sync();
        send_line(2, 0, 1'b0);
        @(negedge clk);
        chk("long_err_long", err_long, 1);
        chk("long_pix_x", pix_x, 0);
        sync();
        clear_errs();
        send_line(2, 0, 1'b0);
        send_beat(1'b1, 1'b1);
        @(negedge clk);
        chk("setwin_err_short", err_short, 1);
        chk("setwin_err_long", err_long, 0);
        sync();
        clear_errs();

        // Downstream stall holds the output register and all counters.
        drain();
        ds_mode = 1;
        idle(2);
        send_beat(1'b0, 1'b0);
        exp_eow = sb[sb.size() - 1];
        bp_x = m_x;
        rts_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rts_o", rts_o, 1);
            chk("bp_eow_o", eow_o, exp_eow);
            chk("bp_rtr_o", rtr_o, 0);
            chk("bp_acc_en", acc_en, 0);
            chk("bp_pix_x", pix_x, bp_x);
            sync();
        end
        rts_i = 1'b0;
        ds_mode = 2;
        rand_line(1'b1);
        ds_mode = 0;

        // Dropping enable mid-frame lets the frame finish, then parks in IDLE.
        while (m_line != H / 2) rand_line(1'b1);
        enable_i = 1'b0;
        finish_frame(1'b1);
        ds_mode = 2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("disabled_rtr_o", rtr_o, 0);
            sync();
        end
        enable_i = 1'b1;
        ds_mode = 0;
        rand_line(1'b1);

        // Reset mid-frame abandons the frame without a frame_done pulse.
        while (m_line != 5) rand_line(1'b1);
        for (int i = 0; i < 10; i++) send_beat(1'b0, 1'b0);
        drain();
        rst = 1'b1;
        enable_i = 1'b0;
        sync();
        rst = 1'b0;
        m_x = 0;
        m_line = 0;
        m_bank = 1'b0;
        m_es = 1'b0;
        m_el = 1'b0;
        check_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_rtr_o", rtr_o, 0);
            sync();
        end
        enable_i = 1'b1;
        ds_mode = 0;
        finish_frame(1'b1);

        drain();
        chk("frame_done_count", fd_seen, fd_exp);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
